bus_sequencer: RTL
==================

Name: bus_sequencer

Overview:
Generates the 6502 PHI2 clock from the 8 MHz board clock, sequences the 6502 reset, and decodes the CPU address bus into the active-low chip selects for RAM, VIA1, VIA2, UART and SID. Slow peripherals (UART, SID) get a stretched PHI2 high phase, so the CPU runs at 1 MHz for RAM/VIA cycles and slower only on those accesses. The block replaces the fixed tie-offs and the free-running divider in the bifröst glue FPGA. The CPU drives the address bus, and this block only observes it.

Parameters:
LOW_CLOCKS, 4, PHI2 low-phase length in clock cycles (≥2)
HIGH_CLOCKS, 4, PHI2 high-phase length for normal devices (≥1)
SLOW_EXTRA, 4, extra high-phase clocks for UART/SID cycles (0 disables stretching)
RESET_CYCLES, 8, complete PHI2 cycles reset6502 stays low after reset_n deasserts (≥1)
IO_PAGE, 8'hDE, addr[15:8] value of the I/O page

Ports:
clock  in  1  8 MHz board clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
addr  in  16  6502 address bus (observed only)
clockout  out  1  PHI2 to the 6502 and the VIAs
reset6502  out  1  active-low 6502 RESB
busen  out  1  6502 BE; high once reset6502 is released
ram_cs  out  1  active-low
via1_cs  out  1  active-low
via2_cs  out  1  active-low
uart_cs  out  1  active-low
sid_cs  out  1  active-low
slow_cycle  out  1  high for the whole PHI2 cycle being stretched (debug)

Behaviour:
- Reset (reset_n low at a posedge) forces the following on the next edge, including mid-phase:
  - clockout=0, reset6502=0, busen=0, all *_cs=1, slow_cycle=0.
  - Phase counter ph=0, reset cycle counter=0.
- Phase counter ph is a registered count.
  - Low phase: ph=0..LOW_CLOCKS-1, clockout=0.
  - High phase: ph=LOW_CLOCKS..LOW_CLOCKS+H-1, clockout=1.
  - H is HIGH_CLOCKS, or HIGH_CLOCKS+SLOW_EXTRA when the latched device is UART or SID.
  - After the last high clock, ph wraps to 0.
  - Default period: 8 clocks (1 MHz); stretched period: 12 clocks.
- Decode sample point is the posedge where ph==LOW_CLOCKS-2, so CS is valid one clock before PHI2 rises. At that edge:
  - addr is decoded and the chip selects and slow flag are registered.
  - They are held until the edge where clockout falls; at that edge all CS deassert (go to 1) in the same cycle as clockout falls.
  - addr changes after the sample point are ignored.
- Decode:
  - addr[15:8]!=IO_PAGE → ram_cs.
  - addr[15:8]==IO_PAGE, slot by addr[7:5]: 000 via1_cs; 001 via2_cs; 010 uart_cs (slow); 011 sid_cs (slow); 100–111 unmapped.
  - Unmapped slots assert no CS and are never stretched.
  - At most one CS is low at any time.
- Reset release:
  - After reset_n goes high, PHI2 runs normally, but the chip selects are suppressed and no stretching occurs.
  - The reset counter increments at each PHI2 falling edge and saturates at RESET_CYCLES.
  - When it reaches RESET_CYCLES, reset6502 and busen go high on that same edge (start of a low phase).
  - From the next decode sample point on, chip selects are enabled.
- slow_cycle goes high at the decode sample point for a slow device and low at the falling edge of clockout.
- SLOW_EXTRA=0: slow devices get a normal cycle and slow_cycle still flags them.

Decomposition:
- Package bus_map_pkg holds:
  - IO_PAGE default.
  - Slot encodings (SLOT_VIA1=3'd0, SLOT_VIA2=3'd1, SLOT_UART=3'd2, SLOT_SID=3'd3).
  - Device enum dev_t {DEV_NONE, DEV_RAM, DEV_VIA1, DEV_VIA2, DEV_UART, DEV_SID}.
  - Function is_slow(dev_t).
- Sub-module io_decode: combinational addr → dev_t, shared with future bus monitors.
- Phase and reset sequencing stay in bus_sequencer.

Test Plan:
1. reset_n low for 3 clocks, then high → clockout first rises 4 clocks after release; reset6502 and busen rise exactly 64 clocks after release; all *_cs stay 1 throughout, even with addr=$DE00.
2. Post-reset, addr=$1234 held → ram_cs low from the clock before each clockout rise until clockout falls; PHI2 period 8, high 4; slow_cycle=0.
3. addr=$DE65 → sid_cs low, clockout high for 8 clocks (period 12), slow_cycle=1 for that cycle; then addr=$DE05 → via1_cs low with period back to 8.
4. addr=$DE90 (unmapped slot 100) → no CS asserted, period 8; addr=$DF00 → ram_cs asserted.
5. addr switched from $0100 to $DE40 during the PHI2 high phase → ram_cs held to the end of that cycle, uart_cs and stretch apply only from the next cycle.
6. reset_n pulsed low during a stretched SID high phase → next edge: clockout=0, sid_cs=1, reset6502=0; the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/bus_map_pkg.sv
// Address map and device types for the bifrost 6502 bus: I/O page, slot
// encodings inside that page, and which devices need a stretched PHI2.
package bus_map_pkg;

   localparam logic [7:0] IO_PAGE_DEFAULT = 8'hDE;

   localparam logic [2:0] SLOT_VIA1 = 3'd0;
   localparam logic [2:0] SLOT_VIA2 = 3'd1;
   localparam logic [2:0] SLOT_UART = 3'd2;
   localparam logic [2:0] SLOT_SID  = 3'd3;

   typedef enum logic [2:0] {
      DEV_NONE,
      DEV_RAM,
      DEV_VIA1,
      DEV_VIA2,
      DEV_UART,
      DEV_SID
   } dev_t;

   // Sequencer state: CPU held in reset while PHI2 warms up, then running.
   typedef enum logic [0:0] {
      SEQ_HOLD,
      SEQ_RUN
   } seq_state_t;

   function automatic logic is_slow(input dev_t dev);
      return (dev == DEV_UART) || (dev == DEV_SID);
   endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// 6502-side bus of the glue FPGA: the address bus observed from the CPU, and
// PHI2, reset, bus enable and the chip selects driven back to the board.
interface bus_sequencer_if;

   logic [15:0] addr;
   logic        clockout;
   logic        reset6502;
   logic        busen;
   logic        ram_cs;
   logic        via1_cs;
   logic        via2_cs;
   logic        uart_cs;
   logic        sid_cs;
   logic        slow_cycle;

   modport master (
      input  addr,
      output clockout, reset6502, busen,
      output ram_cs, via1_cs, via2_cs, uart_cs, sid_cs,
      output slow_cycle
   );

   modport slave (
      output addr,
      input  clockout, reset6502, busen,
      input  ram_cs, via1_cs, via2_cs, uart_cs, sid_cs,
      input  slow_cycle
   );

endinterface

// File: rtl/io_decode.sv
// Combinational 6502 address decoder: maps an address to the device it selects.
// Shared by the bus sequencer and future bus monitors.
module io_decode
   import bus_map_pkg::*;
#(
   parameter logic [7:0] IO_PAGE = IO_PAGE_DEFAULT
) (
   // addr[4:0] select registers inside a device, never the device itself.
   input  logic [15:5] addr,
   output dev_t        dev
);

   // NOTE: every output of an always_comb gets a default first, so no path
   // through the block leaves it unassigned and infers a latch.
   always_comb begin
      dev = DEV_RAM;
      if (addr[15:8] == IO_PAGE) begin
         case (addr[7:5])
            SLOT_VIA1: dev = DEV_VIA1;
            SLOT_VIA2: dev = DEV_VIA2;
            SLOT_UART: dev = DEV_UART;
            SLOT_SID:  dev = DEV_SID;
            default:   dev = DEV_NONE;
         endcase
      end
   end

endmodule

// File: rtl/bus_sequencer.sv
// PHI2 generator, 6502 reset sequencer and chip-select decoder for the bifrost
// glue FPGA. UART/SID accesses get a stretched PHI2 high phase.
module bus_sequencer
   import bus_map_pkg::*;
#(
   parameter int         LOW_CLOCKS   = 4,
   parameter int         HIGH_CLOCKS  = 4,
   parameter int         SLOW_EXTRA   = 4,
   parameter int         RESET_CYCLES = 8,
   parameter logic [7:0] IO_PAGE      = IO_PAGE_DEFAULT
) (
   input logic             clock,
   input logic             reset_n,
   bus_sequencer_if.master bus
);

   localparam int PH_W  = $clog2(LOW_CLOCKS + HIGH_CLOCKS + SLOW_EXTRA);
   localparam int RST_W = $clog2(RESET_CYCLES + 1);

   localparam logic [PH_W-1:0]  PH_SAMPLE    = PH_W'(LOW_CLOCKS - 2);
   localparam logic [PH_W-1:0]  PH_RISE      = PH_W'(LOW_CLOCKS);
   localparam logic [PH_W-1:0]  PH_LAST_NORM = PH_W'(LOW_CLOCKS + HIGH_CLOCKS - 1);
   localparam logic [PH_W-1:0]  PH_LAST_SLOW = PH_W'(LOW_CLOCKS + HIGH_CLOCKS + SLOW_EXTRA - 1);
   localparam logic [RST_W-1:0] RST_DONE     = RST_W'(RESET_CYCLES);

   seq_state_t       state, state_next;
   logic [PH_W-1:0]  ph, ph_next;
   logic [RST_W-1:0] rst_cnt, rst_cnt_next;
   dev_t             dev_dec, dev_q, dev_next;
   logic             slow_q, slow_next;
   logic             sample_pt;
   logic             phi_fall;

   io_decode #(
      .IO_PAGE (IO_PAGE)
   ) u_decode (
      .addr (bus.addr[15:5]),
      .dev  (dev_dec)
   );

   // The high-phase length of the current cycle follows the device latched at
   // its sample point, so a stretched cycle ends on PH_LAST_SLOW.
   assign sample_pt = (ph == PH_SAMPLE);
   assign phi_fall  = (ph == (slow_q ? PH_LAST_SLOW : PH_LAST_NORM));

   // NOTE: registers are updated with non-blocking assignments so every
   // flop samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= SEQ_HOLD;
         ph      <= '0;
         rst_cnt <= '0;
         dev_q   <= DEV_NONE;
         slow_q  <= 1'b0;
      end else begin
         state   <= state_next;
         ph      <= ph_next;
         rst_cnt <= rst_cnt_next;
         dev_q   <= dev_next;
         slow_q  <= slow_next;
      end
   end

   always_comb begin
      ph_next      = phi_fall ? '0 : ph + 1'b1;
      state_next   = state;
      rst_cnt_next = rst_cnt;
      dev_next     = dev_q;
      slow_next    = slow_q;

      // Selects drop together with PHI2; while the CPU is still held in reset
      // nothing is selected and nothing is stretched.
      if (phi_fall) begin
         dev_next  = DEV_NONE;
         slow_next = 1'b0;
      end else if (sample_pt && (state == SEQ_RUN)) begin
         dev_next  = dev_dec;
         slow_next = is_slow(dev_dec);
      end

      case (state)
         SEQ_HOLD: begin
            if (phi_fall) begin
               rst_cnt_next = rst_cnt + 1'b1;
               if (rst_cnt_next == RST_DONE) begin
                  state_next = SEQ_RUN;
               end
            end
         end
         SEQ_RUN: begin
            state_next = SEQ_RUN;
         end
         default: begin
            state_next = SEQ_HOLD;
         end
      endcase
   end

   assign bus.clockout   = (ph >= PH_RISE);
   assign bus.reset6502  = (state == SEQ_RUN);
   assign bus.busen      = (state == SEQ_RUN);
   assign bus.ram_cs     = (dev_q != DEV_RAM);
   assign bus.via1_cs    = (dev_q != DEV_VIA1);
   assign bus.via2_cs    = (dev_q != DEV_VIA2);
   assign bus.uart_cs    = (dev_q != DEV_UART);
   assign bus.sid_cs     = (dev_q != DEV_SID);
   assign bus.slow_cycle = slow_q;

endmodule
